// File: rtl/exers_pkg.sv
// Shared types for the ALU reservation station: field widths, the entry
// record and the writeback tag-match helper.
package exers_pkg;

   localparam int OPW  = 5;   // ALU opcode width
   localparam int ROBW = 8;   // ROB id / operand tag width
   localparam int RDW  = 6;   // destination register width
   localparam int DW   = 32;  // operand data width

   // One reservation-station slot
   typedef struct packed {
      logic            valid;
      logic [OPW-1:0]  op;
      logic [ROBW-1:0] robid;
      logic [RDW-1:0]  rd;
      logic [DW-1:0]   op1_val;
      logic [DW-1:0]   op2_val;
      logic            op1_rdy;
      logic            op2_rdy;
      logic [ROBW-1:0] op1_tag;
      logic [ROBW-1:0] op2_tag;
   } exers_entry_t;

   // True when a valid writeback broadcast carries the tag an operand waits on
   function automatic logic tag_match(input logic            wb_valid,
                                      input logic [ROBW-1:0] wb_robid,
                                      input logic [ROBW-1:0] tag);
      return wb_valid & (wb_robid == tag);
   endfunction

endpackage

// File: rtl/exers_scalu_if.sv
// Dispatch / writeback / issue bundle between the pipeline and the ALU
// reservation station. The master drives dispatch, writeback, stall and
// flush; the slave (the station) drives full and the issue payload.
interface exers_scalu_if;
   import exers_pkg::*;

   logic            dispatch_valid;
   logic [OPW-1:0]  dispatch_op;
   logic [ROBW-1:0] dispatch_robid;
   logic [RDW-1:0]  dispatch_rd;
   logic            dispatch_op1_rdy;
   logic [DW-1:0]   dispatch_op1;
   logic            dispatch_op2_rdy;
   logic [DW-1:0]   dispatch_op2;
   logic            exers_full;
   logic            wb_valid;
   logic [ROBW-1:0] wb_robid;
   logic [DW-1:0]   wb_result;
   logic            exers_scalu_issue;
   logic [OPW-1:0]  exers_scalu_op;
   logic [ROBW-1:0] exers_robid;
   logic [RDW-1:0]  exers_rd;
   logic [DW-1:0]   exers_op1;
   logic [DW-1:0]   exers_op2;
   logic            scalu_stall;
   logic            rob_flush;

   modport master (
      output dispatch_valid, dispatch_op, dispatch_robid, dispatch_rd,
             dispatch_op1_rdy, dispatch_op1, dispatch_op2_rdy, dispatch_op2,
             wb_valid, wb_robid, wb_result, scalu_stall, rob_flush,
      input  exers_full, exers_scalu_issue, exers_scalu_op, exers_robid,
             exers_rd, exers_op1, exers_op2
   );

   modport slave (
      input  dispatch_valid, dispatch_op, dispatch_robid, dispatch_rd,
             dispatch_op1_rdy, dispatch_op1, dispatch_op2_rdy, dispatch_op2,
             wb_valid, wb_robid, wb_result, scalu_stall, rob_flush,
      output exers_full, exers_scalu_issue, exers_scalu_op, exers_robid,
             exers_rd, exers_op1, exers_op2
   );

endinterface

// File: rtl/exers_select.sv
// Ready-vector to one-hot grant for the reservation station.
// Build option EXERS_OLDEST_FIRST_EN: when defined, an age matrix tracks
// allocation order and the oldest ready entry wins; otherwise the lowest
// ready index wins and no age state exists.
module exers_select
   import exers_pkg::*;
#(
   parameter int DEPTH = 8
) (
`ifdef EXERS_OLDEST_FIRST_EN
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic [DEPTH-1:0] i_alloc,
`endif
   input  logic [DEPTH-1:0] i_ready,
   output logic [DEPTH-1:0] o_grant
);

`ifdef EXERS_OLDEST_FIRST_EN
   // r_age[i][j] set means entry i is older than entry j; diagonal stays 0
   logic [DEPTH-1:0] r_age [DEPTH];

   // Age matrix: a newly allocated entry becomes younger than every other slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
      end else if (i_flush) begin
         for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (i_alloc[k]) begin
               for (int j = 0; j < DEPTH; j++) begin
                  r_age[k][j] <= 1'b0;
                  r_age[j][k] <= (j != k);
               end
            end
         end
      end
   end

   // Grant a ready entry that no other ready entry is older than
   always_comb begin
      o_grant = i_ready;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            o_grant[i] = o_grant[i] & ~(i_ready[j] & r_age[j][i]);
         end
      end
   end
`else
   logic w_found;

   // Priority encoder: lowest ready index wins
   always_comb begin
      w_found = 1'b0;
      o_grant = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_grant[i] = i_ready[i] & ~w_found;
         w_found    = w_found | i_ready[i];
      end
   end
`endif

endmodule

// File: rtl/exers_scalu.sv
// ALU reservation station: holds dispatched micro-ops until both operands
// are captured from the writeback broadcast, then issues one ready entry
// per cycle to the single-cycle ALU. Honours ALU stall and ROB flush.
// Build option EXERS_OLDEST_FIRST_EN selects oldest-first issue (see
// exers_select); the default build issues the lowest ready index.
module exers_scalu
   import exers_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int TAGW  = 8
) (
   input logic          clk,
   input logic          rst_n,
   exers_scalu_if.slave bus
);

   localparam int CNTW = $clog2(DEPTH + 1);

   exers_entry_t    r_ent [DEPTH];
   logic [CNTW-1:0] r_count;
   logic            r_full;

   logic [DEPTH-1:0] w_ready;
   logic [DEPTH-1:0] w_grant;
   logic [DEPTH-1:0] w_alloc_oh;
   logic             w_taken;
   logic             w_any_ready;
   logic             w_accept;
   logic             w_issue;
   logic             w_op1_hit;
   logic             w_op2_hit;
   logic [CNTW-1:0]  w_count_nxt;
   exers_entry_t     w_new;
   logic [OPW-1:0]   w_sel_op;
   logic [ROBW-1:0]  w_sel_robid;
   logic [RDW-1:0]   w_sel_rd;
   logic [DW-1:0]    w_sel_op1;
   logic [DW-1:0]    w_sel_op2;

   // Per-entry readiness from registered state, and first free slot
   always_comb begin
      w_taken    = 1'b0;
      w_ready    = '0;
      w_alloc_oh = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_ready[i]    = r_ent[i].valid & r_ent[i].op1_rdy & r_ent[i].op2_rdy;
         w_alloc_oh[i] = ~r_ent[i].valid & ~w_taken;
         w_taken       = w_taken | ~r_ent[i].valid;
      end
   end

   assign w_any_ready = |w_ready;
   // A full station drops the dispatch even if an issue frees a slot now
   assign w_accept    = bus.dispatch_valid & ~r_full & ~bus.rob_flush;
   assign w_issue     = w_any_ready & ~bus.scalu_stall & ~bus.rob_flush;

   exers_select #(.DEPTH(DEPTH)) u_select (
`ifdef EXERS_OLDEST_FIRST_EN
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (bus.rob_flush),
      .i_alloc (w_alloc_oh & {DEPTH{w_accept}}),
`endif
      .i_ready (w_ready),
      .o_grant (w_grant)
   );

   // Build the incoming entry, capturing a same-cycle broadcast for pending operands
   always_comb begin
      w_op1_hit     = ~bus.dispatch_op1_rdy &
                      tag_match(bus.wb_valid, bus.wb_robid, bus.dispatch_op1[TAGW-1:0]);
      w_op2_hit     = ~bus.dispatch_op2_rdy &
                      tag_match(bus.wb_valid, bus.wb_robid, bus.dispatch_op2[TAGW-1:0]);
      w_new         = '0;
      w_new.valid   = 1'b1;
      w_new.op      = bus.dispatch_op;
      w_new.robid   = bus.dispatch_robid;
      w_new.rd      = bus.dispatch_rd;
      w_new.op1_tag = bus.dispatch_op1[TAGW-1:0];
      w_new.op2_tag = bus.dispatch_op2[TAGW-1:0];
      w_new.op1_rdy = bus.dispatch_op1_rdy | w_op1_hit;
      w_new.op2_rdy = bus.dispatch_op2_rdy | w_op2_hit;
      w_new.op1_val = bus.dispatch_op1_rdy ? bus.dispatch_op1 :
                      (w_op1_hit ? bus.wb_result : 32'h0000_0000);
      w_new.op2_val = bus.dispatch_op2_rdy ? bus.dispatch_op2 :
                      (w_op2_hit ? bus.wb_result : 32'h0000_0000);
   end

   // Occupancy after this cycle's accept and issue
   always_comb begin
      case ({w_accept, w_issue})
         2'b10:   w_count_nxt = r_count + CNTW'(1);
         2'b01:   w_count_nxt = r_count - CNTW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // One-hot mux of the granted entry onto the issue payload
   always_comb begin
      w_sel_op    = '0;
      w_sel_robid = '0;
      w_sel_rd    = '0;
      w_sel_op1   = '0;
      w_sel_op2   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_sel_op    = w_sel_op    | ({OPW{w_grant[i]}}  & r_ent[i].op);
         w_sel_robid = w_sel_robid | ({ROBW{w_grant[i]}} & r_ent[i].robid);
         w_sel_rd    = w_sel_rd    | ({RDW{w_grant[i]}}  & r_ent[i].rd);
         w_sel_op1   = w_sel_op1   | ({DW{w_grant[i]}}   & r_ent[i].op1_val);
         w_sel_op2   = w_sel_op2   | ({DW{w_grant[i]}}   & r_ent[i].op2_val);
      end
   end

   // Entry state: wakeup, free on issue, allocate on dispatch; flush/reset clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else if (bus.rob_flush) begin
         for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_ent[i].valid && !r_ent[i].op1_rdy &&
                tag_match(bus.wb_valid, bus.wb_robid, r_ent[i].op1_tag)) begin
               r_ent[i].op1_rdy <= 1'b1;
               r_ent[i].op1_val <= bus.wb_result;
            end
            if (r_ent[i].valid && !r_ent[i].op2_rdy &&
                tag_match(bus.wb_valid, bus.wb_robid, r_ent[i].op2_tag)) begin
               r_ent[i].op2_rdy <= 1'b1;
               r_ent[i].op2_val <= bus.wb_result;
            end
            if (w_issue && w_grant[i]) begin
               r_ent[i].valid <= 1'b0;
            end
            // Allocation only targets slots free before this edge, never the issued one
            if (w_accept && w_alloc_oh[i]) begin
               r_ent[i] <= w_new;
            end
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNTW'(DEPTH));
      end
   end

   assign bus.exers_full        = r_full;
   assign bus.exers_scalu_issue = w_issue;
   assign bus.exers_scalu_op    = w_sel_op;
   assign bus.exers_robid       = w_sel_robid;
   assign bus.exers_rd          = w_sel_rd;
   assign bus.exers_op1         = w_sel_op1;
   assign bus.exers_op2         = w_sel_op2;

endmodule

// File: tb/tb_exers_scalu.sv
// Self-checking bench for exers_scalu: directed scenarios followed by
// randomized traffic, all checked against a slot-array reference model.
// Honours EXERS_OLDEST_FIRST_EN for the expected selection policy.
module tb_exers_scalu;
   import exers_pkg::*;

   localparam int DEPTH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   exers_scalu_if bus_if();

   exers_scalu #(.DEPTH(DEPTH), .TAGW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      bit        v;
      bit [4:0]  op;
      bit [7:0]  rob;
      bit [5:0]  rd;
      bit [31:0] a, b;
      bit        ar, br;
      bit [7:0]  at, bt;
      int        seq;
   } ment_t;

   ment_t m [DEPTH];
   int    m_seq = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) if (m[i].v) c++;
      return c;
   endfunction

   // Entry the station should issue next, or -1 when nothing is ready
   function automatic int model_sel();
      int s = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (m[i].v && m[i].ar && m[i].br) begin
`ifdef EXERS_OLDEST_FIRST_EN
            if (s < 0 || m[i].seq < m[s].seq) s = i;
`else
            if (s < 0) s = i;
`endif
         end
      end
      return s;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
   endtask

   task automatic set_idle();
      bus_if.dispatch_valid   = 1'b0;
      bus_if.dispatch_op      = 5'd0;
      bus_if.dispatch_robid   = 8'd0;
      bus_if.dispatch_rd      = 6'd0;
      bus_if.dispatch_op1_rdy = 1'b0;
      bus_if.dispatch_op1     = 32'd0;
      bus_if.dispatch_op2_rdy = 1'b0;
      bus_if.dispatch_op2     = 32'd0;
      bus_if.wb_valid         = 1'b0;
      bus_if.wb_robid         = 8'd0;
      bus_if.wb_result        = 32'd0;
      bus_if.scalu_stall      = 1'b0;
      bus_if.rob_flush        = 1'b0;
   endtask

   task automatic set_disp(input logic [4:0] op, input logic [7:0] rob, input logic [5:0] rd,
                           input logic r1, input logic [31:0] v1,
                           input logic r2, input logic [31:0] v2);
      bus_if.dispatch_valid   = 1'b1;
      bus_if.dispatch_op      = op;
      bus_if.dispatch_robid   = rob;
      bus_if.dispatch_rd      = rd;
      bus_if.dispatch_op1_rdy = r1;
      bus_if.dispatch_op1     = v1;
      bus_if.dispatch_op2_rdy = r2;
      bus_if.dispatch_op2     = v2;
   endtask

   // Check outputs mid-cycle against the model, clock once, advance the model
   task automatic step();
      int sel, slot;
      bit full, exp_issue;
      #1;
      sel       = model_sel();
      full      = (model_count() == DEPTH);
      exp_issue = (sel >= 0) && !bus_if.scalu_stall && !bus_if.rob_flush;
      chk("full", bus_if.exers_full, full);
      chk("issue", bus_if.exers_scalu_issue, exp_issue);
      if (exp_issue) begin
         chk("op",    bus_if.exers_scalu_op, m[sel].op);
         chk("robid", bus_if.exers_robid,    m[sel].rob);
         chk("rd",    bus_if.exers_rd,       m[sel].rd);
         chk("op1",   bus_if.exers_op1,      m[sel].a);
         chk("op2",   bus_if.exers_op2,      m[sel].b);
      end
      @(posedge clk);
      if (!rst_n || bus_if.rob_flush) begin
         model_clear();
      end else begin
         slot = -1;
         if (bus_if.dispatch_valid && !full) begin
            for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].v) slot = i;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (m[i].v && !m[i].ar && bus_if.wb_valid && m[i].at == bus_if.wb_robid) begin
               m[i].ar = 1'b1; m[i].a = bus_if.wb_result;
            end
            if (m[i].v && !m[i].br && bus_if.wb_valid && m[i].bt == bus_if.wb_robid) begin
               m[i].br = 1'b1; m[i].b = bus_if.wb_result;
            end
         end
         if (exp_issue) m[sel].v = 1'b0;
         if (slot >= 0) begin
            m[slot].v   = 1'b1;
            m[slot].op  = bus_if.dispatch_op;
            m[slot].rob = bus_if.dispatch_robid;
            m[slot].rd  = bus_if.dispatch_rd;
            m[slot].at  = bus_if.dispatch_op1[7:0];
            m[slot].bt  = bus_if.dispatch_op2[7:0];
            m[slot].ar  = bus_if.dispatch_op1_rdy ||
                          (bus_if.wb_valid && bus_if.dispatch_op1[7:0] == bus_if.wb_robid);
            m[slot].br  = bus_if.dispatch_op2_rdy ||
                          (bus_if.wb_valid && bus_if.dispatch_op2[7:0] == bus_if.wb_robid);
            m[slot].a   = bus_if.dispatch_op1_rdy ? bus_if.dispatch_op1 : bus_if.wb_result;
            m[slot].b   = bus_if.dispatch_op2_rdy ? bus_if.dispatch_op2 : bus_if.wb_result;
            m[slot].seq = m_seq;
            m_seq++;
         end
      end
      #1;
   endtask

   initial begin
      set_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      rst_n = 1'b1;

      // Reset state
      #1;
      chk("rst_full",  bus_if.exers_full, 1'b0);
      chk("rst_issue", bus_if.exers_scalu_issue, 1'b0);

      // 1: both operands ready, issue next cycle
      set_disp(5'd0, 8'd3, 6'd1, 1'b1, 32'd5, 1'b1, 32'd7);
      step();
      set_idle(); #1;
      chk("t1_issue", bus_if.exers_scalu_issue, 1'b1);
      chk("t1_op1",   bus_if.exers_op1, 32'd5);
      chk("t1_op2",   bus_if.exers_op2, 32'd7);
      chk("t1_robid", bus_if.exers_robid, 8'd3);
      step();
      set_idle(); #1;
      chk("t1_freed", bus_if.exers_scalu_issue, 1'b0);
      step();

      // 2: op1 waits on tag 0x12, woken by a later broadcast
      set_disp(5'd1, 8'd4, 6'd2, 1'b0, 32'h0000_0012, 1'b1, 32'd1);
      step();
      set_idle(); step();
      bus_if.wb_valid = 1'b1; bus_if.wb_robid = 8'h12; bus_if.wb_result = 32'hDEAD;
      step();
      set_idle(); #1;
      chk("t2_issue", bus_if.exers_scalu_issue, 1'b1);
      chk("t2_op1",   bus_if.exers_op1, 32'hDEAD);
      step();

      // 3: broadcast in the dispatch cycle
      set_disp(5'd2, 8'd5, 6'd3, 1'b0, 32'h0000_0020, 1'b1, 32'd3);
      bus_if.wb_valid = 1'b1; bus_if.wb_robid = 8'h20; bus_if.wb_result = 32'd9;
      step();
      set_idle(); #1;
      chk("t3_issue", bus_if.exers_scalu_issue, 1'b1);
      chk("t3_op1",   bus_if.exers_op1, 32'd9);
      step();

      // 4: fill under stall, ninth dispatch dropped, drain in order
      for (int k = 0; k < DEPTH; k++) begin
         set_disp(5'd3, 8'(k), 6'(k), 1'b1, 32'(k), 1'b1, 32'(k + 100));
         bus_if.scalu_stall = 1'b1;
         step();
      end
      set_disp(5'd3, 8'd99, 6'd9, 1'b1, 32'd1, 1'b1, 32'd2);
      bus_if.scalu_stall = 1'b1;
      #1;
      chk("t4_full",  bus_if.exers_full, 1'b1);
      chk("t4_stall", bus_if.exers_scalu_issue, 1'b0);
      step();
      for (int k = 0; k < DEPTH; k++) begin
         set_idle(); #1;
         chk("t4_drain", bus_if.exers_robid, 32'(k));
         step();
      end
      set_idle(); #1;
      chk("t4_empty", bus_if.exers_scalu_issue, 1'b0);
      step();

      // 5: flush with a concurrent dispatch
      for (int k = 0; k < 5; k++) begin
         set_disp(5'd4, 8'(k + 40), 6'(k), 1'b1, 32'd1, 1'b1, 32'd2);
         bus_if.scalu_stall = 1'b1;
         step();
      end
      set_disp(5'd4, 8'd77, 6'd7, 1'b1, 32'd1, 1'b1, 32'd2);
      bus_if.rob_flush = 1'b1;
      step();
      set_idle(); #1;
      chk("t5_issue", bus_if.exers_scalu_issue, 1'b0);
      chk("t5_full",  bus_if.exers_full, 1'b0);
      step(); step();

      // 6: reset with pending entries
      for (int k = 0; k < 3; k++) begin
         set_disp(5'd5, 8'(k + 60), 6'(k), 1'b1, 32'd1, 1'b1, 32'd2);
         bus_if.scalu_stall = 1'b1;
         step();
      end
      set_idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; #1;
      chk("t6_full",  bus_if.exers_full, 1'b0);
      chk("t6_issue", bus_if.exers_scalu_issue, 1'b0);
      step(); step();

      // Randomized traffic
      for (int c = 0; c < 2000; c++) begin
         set_idle();
         rst_n = ($urandom_range(0, 199) != 0);
         bus_if.rob_flush   = ($urandom_range(0, 49) == 0);
         bus_if.scalu_stall = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 9) < 6) begin
            set_disp(5'($urandom), 8'($urandom), 6'($urandom),
                     1'($urandom_range(0, 1)),
                     {24'($urandom), 8'(32'h10 + $urandom_range(0, 7))},
                     1'($urandom_range(0, 1)),
                     {24'($urandom), 8'(32'h10 + $urandom_range(0, 7))});
         end
         bus_if.wb_valid  = 1'($urandom_range(0, 1));
         bus_if.wb_robid  = 8'(32'h10 + $urandom_range(0, 7));
         bus_if.wb_result = $urandom;
         step();
      end

      rst_n = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
